// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues 2-bit ALU operations and issues them one at a time
// to an external combinational ALU. It captures each result and holds it
// until the downstream side accepts it.
//
// Ports:
//   clk, rst_n              clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready       upstream handshake for {in_a, in_b, in_sel}
//   alu_a, alu_b, alu_sel   operands/opcode driven to the external ALU
//   alu_result, alu_carry   combinational ALU response
//   out_valid/out_ready     downstream handshake for the captured result
//   out_result, out_carry   captured ALU result and carry
//   out_sel, out_err        opcode echo and illegal-opcode flag
//   op_count                completed downstream transfers, wraps at 256
module alu_issue_ctrl #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_a,
    input  logic [1:0] in_b,
    input  logic [2:0] in_sel,
    output logic [1:0] alu_a,
    output logic [1:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [1:0] alu_result,
    input  logic       alu_carry,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_result,
    output logic       out_carry,
    output logic [2:0] out_sel,
    output logic       out_err,
    output logic [7:0] op_count
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] SEL_LAST_LEGAL = 3'b100;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] sel;
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    op_t              mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             accept_en;
    op_t              issue_op;
    state_t           state;
    state_t           state_nxt;

    logic push;
    logic pop;
    logic capture;
    logic retire;
    logic empty;
    logic illegal;

    // Ready comes only from registers; accept_en keeps it low until the first
    // edge after reset release.
    assign in_ready = accept_en && (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign empty    = (count == '0);
    assign illegal  = (issue_op.sel > SEL_LAST_LEGAL);

    // The ALU is driven straight from the issue registers.
    assign alu_a   = issue_op.a;
    assign alu_b   = issue_op.b;
    assign alu_sel = issue_op.sel;

    // Queue storage: no reset needed, validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= op_t'({in_a, in_b, in_sel});
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            accept_en <= 1'b0;
        end else begin
            accept_en <= 1'b1;
            if (push) begin
                wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            end
            case ({push, pop})
                2'b10:   count <= CNT_W'(count + CNT_W'(1));
                2'b01:   count <= CNT_W'(count - CNT_W'(1));
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = empty ? IDLE : ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM control outputs.
    always_comb begin
        pop     = 1'b0;
        capture = 1'b0;
        retire  = 1'b0;
        case (state)
            IDLE: begin
                pop = !empty;
            end
            ISSUE: begin
                capture = 1'b1;
            end
            HOLD: begin
                retire = out_ready;
                pop    = out_ready && !empty;
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    // Issue registers and captured result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_op   <= '0;
            out_valid  <= 1'b0;
            out_result <= 2'b00;
            out_carry  <= 1'b0;
            out_sel    <= 3'b000;
            out_err    <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            if (pop) begin
                issue_op <= mem[rd_ptr];
            end
            if (capture) begin
                out_valid <= 1'b1;
                out_sel   <= issue_op.sel;
                // Illegal opcodes still take an issue slot, but whatever the
                // ALU returned is replaced by a zero result.
                if (illegal) begin
                    out_result <= 2'b00;
                    out_carry  <= 1'b0;
                    out_err    <= 1'b1;
                end else begin
                    out_result <= alu_result;
                    out_carry  <= alu_carry;
                    out_err    <= 1'b0;
                end
            end else if (retire) begin
                out_valid <= 1'b0;
                op_count  <= 8'(op_count + 8'd1);
            end
        end
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: operation queue entries, power of two, minimum 2.
REQ-002 The block SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous reset, active-low.
REQ-004 The block SHALL have port in_valid, input, 1: upstream operation valid.
REQ-005 The block SHALL have port in_ready, output, 1: queue can accept an operation.
REQ-006 The block SHALL have ports in_a and in_b, input, 2 each: operands.
REQ-007 The block SHALL have port in_sel, input, 3: opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101-111 illegal).
REQ-008 The block SHALL have ports alu_a and alu_b, output, 2 each, and alu_sel, output, 3: drive the combinational 2-bit ALU.
REQ-009 The block SHALL have ports alu_result, input, 2, and alu_carry, input, 1: ALU outputs.
REQ-010 The block SHALL have port out_valid, output, 1: captured result valid.
REQ-011 The block SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-012 The block SHALL have ports out_result, output, 2; out_carry, output, 1; out_sel, output, 3 (opcode echo); out_err, output, 1 (illegal opcode).
REQ-013 The block SHALL have port op_count, output, 8: completed-transfer counter.

Function
REQ-014 Queue SHALL be FIFO_DEPTH-entry FIFO of {a, b, sel}; in_ready = (count != FIFO_DEPTH), derived from registered count only.
REQ-015 Push SHALL occur on a rising edge with in_valid && in_ready; in_valid with in_ready low SHALL be ignored, nothing stored.
REQ-016 Full queue SHALL NOT accept a push in the same cycle as a pop; simultaneous push and pop when not full and not empty SHALL leave count unchanged.
REQ-017 Read/write pointers SHALL wrap modulo FIFO_DEPTH; order SHALL be strictly preserved across wrap.
REQ-018 FSM states SHALL be IDLE, ISSUE, HOLD.
REQ-019 IDLE: if queue non-empty, pop head into issue registers, go to ISSUE; else stay.
REQ-020 alu_a, alu_b, alu_sel SHALL be driven directly from issue registers and hold their last value outside ISSUE.
REQ-021 ISSUE (exactly one cycle): at end of cycle, capture alu_result, alu_carry into out_result, out_carry; copy issue sel to out_sel; set out_valid; go to HOLD.
REQ-022 Illegal opcode: ISSUE still occurs; captured out_result SHALL be 00, out_carry 0, out_err 1; legal opcode captures out_err 0.
REQ-023 HOLD: out_* SHALL be stable while out_valid && !out_ready.
REQ-024 HOLD with out_ready high: clear out_valid, increment op_count (wrap 255 -> 0); if queue non-empty pop next and go to ISSUE, else go to IDLE.
REQ-025 Latency: operation pushed into empty queue while IDLE at edge E0 SHALL be popped at E1, show out_valid high after E2.
REQ-026 Sustained throughput with out_ready held high SHALL be one result per two cycles.
REQ-027 Push into the queue SHALL continue in every state, independent of FSM.

Reset
REQ-028 rst_n low SHALL immediately, without clock: empty queue, zero pointers/count, FSM to IDLE, clear issue registers.
REQ-029 During reset: in_ready 0, out_valid 0, out_result 00, out_carry 0, out_sel 000, out_err 0, alu_a/alu_b 00, alu_sel 000, op_count 0.
REQ-030 Reset mid-operation SHALL discard queued and in-flight operations; no result SHALL emerge after release.
REQ-031 in_ready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-032 Single op: push A=01,B=10,sel=010 (AND) into idle block -> out_valid after 2 edges, out_result 00, out_carry 0, out_sel 010, op_count 1 after transfer.
REQ-033 Carry: push A=11,B=01,sel=000 -> out_result 00, out_carry 1, out_err 0.
REQ-034 Backpressure/full: out_ready 0, push 5 ops (ADD,OR,XOR,AND,ADD) -> 1 in HOLD plus 4 queued, in_ready 0, 6th not accepted; release out_ready -> results in push order, in_ready 1 after first pop.
REQ-035 Illegal: push sel=110 A=11,B=11 -> out_err 1, out_result 00, out_carry 0; next legal op out_err 0.
REQ-036 Reset mid-op: 3 ops queued, rst_n low during ISSUE -> all outputs at reset values asynchronously; after release no out_valid until a new push.
REQ-037 Wrap: 300 random ops, out_ready random -> scoreboard matches ALU model in order, op_count = 300 mod 256 = 44.
